// File: rtl/mesi_bus_if.sv
// mesi_bus_if: request, snoop and response signals between the three MESI cache
// controllers (master side) and the memory-side bus responder (slave side).
interface mesi_bus_if;
    logic [2:0]       req_valid;
    logic [2:0][1:0]  req_cmd;
    logic [2:0][4:0]  req_tag;
    logic [2:0][7:0]  req_data;
    logic [2:0]       req_ready;

    logic             snoop_valid;
    logic [1:0]       snoop_cmd;
    logic [4:0]       snoop_tag;
    logic [2:0]       snoop_mask;
    logic [2:0]       snoop_hit;
    logic [2:0]       snoop_dirty;
    logic [2:0][7:0]  snoop_data;

    logic             resp_valid;
    logic [1:0]       resp_id;
    logic [7:0]       resp_data;
    logic             resp_shared;
    logic             inv_valid;
    logic [2:0]       inv_mask;
    logic             proto_err;

    modport slave (
        input  req_valid, req_cmd, req_tag, req_data,
        input  snoop_hit, snoop_dirty, snoop_data,
        output req_ready,
        output snoop_valid, snoop_cmd, snoop_tag, snoop_mask,
        output resp_valid, resp_id, resp_data, resp_shared,
        output inv_valid, inv_mask, proto_err
    );

    modport master (
        output req_valid, req_cmd, req_tag, req_data,
        output snoop_hit, snoop_dirty, snoop_data,
        input  req_ready,
        input  snoop_valid, snoop_cmd, snoop_tag, snoop_mask,
        input  resp_valid, resp_id, resp_data, resp_shared,
        input  inv_valid, inv_mask, proto_err
    );
endinterface

// File: rtl/mesi_bus_responder.sv
// mesi_bus_responder: memory-side responder for the three-processor MESI snooping
// bus. Round-robin arbitration, snoop broadcast, dirty-owner retirement to the
// 32x8 main memory, and fill response to the requester.
// Optional feature: define MESI_RESP_C2C_EN for cache-to-cache forwarding, where
// the dirty owner's data is returned straight from WB instead of re-reading memory.
//
//   state | meaning
//   IDLE  | waiting for any req_valid, arbitrate round-robin
//   SNOOP | broadcast snoop, sample hit/dirty/data from the other caches
//   WB    | retire dirty owner's line into memory
//   READ  | fetch fill data from memory
//   WRITE | commit a WriteBack into memory
//   RESP  | one-cycle response (and invalidate pulse for WriteMiss/Invalidate)
module mesi_bus_responder (
    input  logic      clk,
    input  logic      rst,
    mesi_bus_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SNOOP, WB, READ, WRITE, RESP} state_t;

    localparam logic [1:0] CMD_READ_MISS  = 2'b00;
    localparam logic [1:0] CMD_WRITE_MISS = 2'b01;
    localparam logic [1:0] CMD_INVALIDATE = 2'b10;
    localparam logic [1:0] CMD_WRITE_BACK = 2'b11;

    state_t     state, stateNext;

    logic [1:0] lastGrant;
    logic [1:0] grantIdx;
    logic       grantFound;
    logic [1:0] probe;

    logic [1:0] curIdx;
    logic [1:0] curCmd;
    logic [4:0] curTag;
    logic [7:0] curData;
    logic [2:0] curOneHot;
    logic [2:0] curMask;

    logic [2:0] maskedHit;
    logic [2:0] maskedDirty;
    logic       multiDirty;
    logic [7:0] ownerDataNow;

    logic [2:0] hitReg;
    logic [7:0] ownerData;
    logic [7:0] respDataReg;
    logic       protoErrReg;

    logic [7:0] mem [32];

    assign curOneHot   = 3'b001 << curIdx;
    assign curMask     = ~curOneHot;
    assign maskedHit   = bus.snoop_hit & curMask;
    assign maskedDirty = bus.snoop_dirty & curMask;
    assign multiDirty  = (maskedDirty[0] & maskedDirty[1]) |
                         (maskedDirty[0] & maskedDirty[2]) |
                         (maskedDirty[1] & maskedDirty[2]);
    assign bus.proto_err = protoErrReg;

    // Round-robin pick: scan the three ports starting just after the last grant.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = 2'd0;
        probe      = lastGrant;
        for (int k = 0; k < 3; k++) begin
            probe = (probe == 2'd2) ? 2'd0 : probe + 2'd1;
            if (!grantFound && bus.req_valid[probe]) begin
                grantFound = 1'b1;
                grantIdx   = probe;
            end
        end
    end

    // Owner is the lowest-indexed cache reporting a dirty copy.
    always_comb begin
        ownerDataNow = bus.snoop_data[2];
        if (maskedDirty[0]) begin
            ownerDataNow = bus.snoop_data[0];
        end else if (maskedDirty[1]) begin
            ownerDataNow = bus.snoop_data[1];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode and state-qualified bus outputs.
    always_comb begin
        stateNext        = state;
        bus.req_ready    = 3'b000;
        bus.snoop_valid  = 1'b0;
        bus.snoop_cmd    = 2'b00;
        bus.snoop_tag    = 5'd0;
        bus.snoop_mask   = 3'b000;
        bus.resp_valid   = 1'b0;
        bus.resp_id      = 2'b00;
        bus.resp_data    = 8'd0;
        bus.resp_shared  = 1'b0;
        bus.inv_valid    = 1'b0;
        bus.inv_mask     = 3'b000;
        case (state)
            IDLE: begin
                if (grantFound) begin
                    stateNext = SNOOP;
                end
            end
            SNOOP: begin
                bus.req_ready   = curOneHot;
                bus.snoop_valid = 1'b1;
                bus.snoop_cmd   = curCmd;
                bus.snoop_tag   = curTag;
                bus.snoop_mask  = curMask;
                case (curCmd)
                    CMD_WRITE_BACK: stateNext = WRITE;
                    CMD_INVALIDATE: stateNext = RESP;
                    default:        stateNext = (|maskedDirty) ? WB : READ;
                endcase
            end
            WB: begin
`ifdef MESI_RESP_C2C_EN
                stateNext = RESP;
`else
                stateNext = READ;
`endif
            end
            READ:  stateNext = RESP;
            WRITE: stateNext = RESP;
            RESP: begin
                bus.resp_valid  = 1'b1;
                bus.resp_id     = curIdx + 2'd1;
                bus.resp_data   = (curCmd == CMD_INVALIDATE) ? 8'd0 : respDataReg;
                bus.resp_shared = (curCmd == CMD_READ_MISS) & (|hitReg);
                if (curCmd == CMD_WRITE_MISS || curCmd == CMD_INVALIDATE) begin
                    bus.inv_valid = 1'b1;
                    bus.inv_mask  = hitReg;
                end
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Transaction latches: grant capture, snoop sampling, fill data, sticky protocol error.
    always_ff @(posedge clk) begin
        if (rst) begin
            lastGrant   <= 2'd2;
            curIdx      <= 2'd0;
            curCmd      <= 2'b00;
            curTag      <= 5'd0;
            curData     <= 8'd0;
            hitReg      <= 3'b000;
            ownerData   <= 8'd0;
            respDataReg <= 8'd0;
            protoErrReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantFound) begin
                        lastGrant <= grantIdx;
                        curIdx    <= grantIdx;
                        curCmd    <= bus.req_cmd[grantIdx];
                        curTag    <= bus.req_tag[grantIdx];
                        curData   <= bus.req_data[grantIdx];
                    end
                end
                SNOOP: begin
                    hitReg    <= maskedHit;
                    ownerData <= ownerDataNow;
                    if (multiDirty) begin
                        protoErrReg <= 1'b1;
                    end
                end
                WB: begin
`ifdef MESI_RESP_C2C_EN
                    respDataReg <= ownerData;
`endif
                end
                READ:  respDataReg <= mem[curTag];
                WRITE: respDataReg <= curData;
                default: ;
            endcase
        end
    end

    // Main memory: not reset; a reset cycle suppresses any pending write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == WB) begin
                mem[curTag] <= ownerData;
            end else if (state == WRITE) begin
                mem[curTag] <= curData;
            end
        end
    end
endmodule

// File: tb/tb_mesi_bus_responder.sv
// tb_mesi_bus_responder: randomized + directed stimulus with a scoreboard.
// The reference model applies the MESI bus rules transaction by transaction;
// a monitor process checks grants, snoop masks and responses as they appear.
module tb_mesi_bus_responder;
    logic clk;
    logic rst;
    int   cyc;

    mesi_bus_if bus();

    mesi_bus_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        logic       shared;
        logic       inv;
        logic [2:0] invMask;
        logic       perr;
        int         lat;
    } resp_t;

    resp_t      respQ[$];
    logic [2:0] grantQ[$];

    int nChecks;
    int nFail;

    logic [7:0] mdlMem [32];
    int         lastGrantM;
    logic       protoM;

    logic [1:0] cmdA  [3];
    logic [4:0] tagA  [3];
    logic [7:0] dataA [3];
    logic [2:0] snHit;
    logic [2:0] snDirty;
    logic [7:0] snData [3];

    int         readyCyc;
    logic [2:0] readyOH;
    resp_t      monE;
    logic [2:0] monG;

`ifdef MESI_RESP_C2C_EN
    localparam int DIRTY_LAT = 3;
`else
    localparam int DIRTY_LAT = 4;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected outcome of one transaction from requester r, using the current snoop inputs.
    task automatic modelTxn(input int r);
        resp_t      e;
        logic [2:0] others;
        logic [2:0] mh;
        logic [2:0] md;
        int         owner;
        int         nd;
        others    = 3'b111;
        others[r] = 1'b0;
        mh        = snHit & others;
        md        = snDirty & others;
        owner     = -1;
        nd        = 0;
        for (int i = 0; i < 3; i++) begin
            if (md[i]) begin
                nd++;
                if (owner < 0) owner = i;
            end
        end
        if (nd >= 2) protoM = 1'b1;
        e.id      = 2'(r + 1);
        e.shared  = 1'b0;
        e.inv     = 1'b0;
        e.invMask = 3'b000;
        e.lat     = 3;
        case (cmdA[r])
            2'b11: begin
                mdlMem[tagA[r]] = dataA[r];
                e.data          = dataA[r];
            end
            2'b10: begin
                e.data    = 8'd0;
                e.inv     = 1'b1;
                e.invMask = mh;
                e.lat     = 2;
            end
            default: begin
                if (owner >= 0) begin
                    mdlMem[tagA[r]] = snData[owner];
                    e.data          = snData[owner];
                    e.lat           = DIRTY_LAT;
                end else begin
                    e.data = mdlMem[tagA[r]];
                end
                if (cmdA[r] == 2'b00) begin
                    e.shared = |mh;
                end else begin
                    e.inv     = 1'b1;
                    e.invMask = mh;
                end
            end
        endcase
        e.perr = protoM;
        respQ.push_back(e);
    endtask

    task automatic applySnoop();
        bus.snoop_hit   = snHit;
        bus.snoop_dirty = snDirty;
        for (int i = 0; i < 3; i++) bus.snoop_data[i] = snData[i];
    endtask

    // Raise requests on the ports in pend; predict grant order and responses; wait for completion.
    task automatic issue(input logic [2:0] pend);
        logic [2:0] left;
        logic [2:0] oh;
        int         p;
        int         budget;
        left = pend;
        while (left != 3'b000) begin
            p = lastGrantM;
            do p = (p + 1) % 3; while (!left[p]);
            left[p]    = 1'b0;
            lastGrantM = p;
            oh         = 3'b000;
            oh[p]      = 1'b1;
            grantQ.push_back(oh);
            modelTxn(p);
        end
        @(negedge clk);
        applySnoop();
        for (int i = 0; i < 3; i++) begin
            bus.req_cmd[i]  = cmdA[i];
            bus.req_tag[i]  = tagA[i];
            bus.req_data[i] = dataA[i];
        end
        bus.req_valid = pend;
        budget        = 0;
        while ((bus.req_valid != 3'b000 || respQ.size() != 0) && budget < 60) begin
            @(negedge clk);
            bus.req_valid = bus.req_valid & ~bus.req_ready;
            budget++;
        end
        if (budget >= 60) begin
            chk("transaction_timeout", 32'(budget), 32'd0);
            bus.req_valid = 3'b000;
            respQ.delete();
            grantQ.delete();
        end
    endtask

    task automatic setSingle(input int r, input logic [1:0] c, input logic [4:0] t, input logic [7:0] d);
        cmdA[r]  = c;
        tagA[r]  = t;
        dataA[r] = d;
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant or a response.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req_ready != 3'b000) begin
                readyCyc = cyc;
                readyOH  = bus.req_ready;
                if (grantQ.size() == 0) begin
                    chk("unexpected_grant", 32'(bus.req_ready), 32'd0);
                end else begin
                    monG = grantQ.pop_front();
                    chk("req_ready", 32'(bus.req_ready), 32'(monG));
                end
            end
            if (bus.snoop_valid) begin
                chk("snoop_mask", 32'(bus.snoop_mask), 32'(~readyOH & 3'b111));
            end
            if (bus.resp_valid) begin
                if (respQ.size() == 0) begin
                    chk("unexpected_resp", 32'(bus.resp_id), 32'd0);
                end else begin
                    monE = respQ.pop_front();
                    chk("resp_id",     32'(bus.resp_id),     32'(monE.id));
                    chk("resp_data",   32'(bus.resp_data),   32'(monE.data));
                    chk("resp_shared", 32'(bus.resp_shared), 32'(monE.shared));
                    chk("inv_valid",   32'(bus.inv_valid),   32'(monE.inv));
                    chk("inv_mask",    32'(bus.inv_mask),    32'(monE.invMask));
                    chk("proto_err",   32'(bus.proto_err),   32'(monE.perr));
                    chk("latency",     32'(cyc - readyCyc + 1), 32'(monE.lat));
                end
            end
        end
    end

    function automatic logic [31:0] allOutputs();
        return {1'b0, bus.req_ready, bus.snoop_valid, bus.snoop_cmd, bus.snoop_tag,
                bus.snoop_mask, bus.resp_valid, bus.resp_id, bus.resp_data,
                bus.resp_shared, bus.inv_valid, bus.inv_mask, bus.proto_err};
    endfunction

    initial begin
        int budget;
        logic [2:0] pend;
        nChecks    = 0;
        nFail      = 0;
        cyc        = 0;
        readyCyc   = 0;
        readyOH    = 3'b000;
        lastGrantM = 2;
        protoM     = 1'b0;
        rst        = 1'b1;
        bus.req_valid = 3'b000;
        for (int i = 0; i < 3; i++) begin
            cmdA[i] = 2'b00; tagA[i] = 5'd0; dataA[i] = 8'd0; snData[i] = 8'd0;
            bus.req_cmd[i] = 2'b00; bus.req_tag[i] = 5'd0; bus.req_data[i] = 8'd0;
        end
        snHit = 3'b000;
        snDirty = 3'b000;
        applySnoop();
        repeat (3) @(negedge clk);
        chk("reset_outputs", allOutputs(), 32'd0);
        rst = 1'b0;

        // Fill every memory line with a known value via WriteBacks from random ports.
        for (int t = 0; t < 32; t++) begin
            int r;
            r = int'($urandom_range(2));
            setSingle(r, 2'b11, 5'(t), 8'($urandom_range(255)));
            pend = 3'b000; pend[r] = 1'b1;
            issue(pend);
        end

        // WriteBack P1 0A=3C, then clean ReadMiss from P2.
        setSingle(0, 2'b11, 5'h0A, 8'h3C); issue(3'b001);
        setSingle(1, 2'b00, 5'h0A, 8'h00); issue(3'b010);
        // ReadMiss from P3 with P1 holding a clean copy.
        snHit = 3'b001; setSingle(2, 2'b00, 5'h0A, 8'h00); issue(3'b100);
        // WriteMiss from P1 with P2 dirty owner (77); then confirm memory got 77.
        snHit = 3'b010; snDirty = 3'b010; snData[1] = 8'h77;
        setSingle(0, 2'b01, 5'h04, 8'h00); issue(3'b001);
        snHit = 3'b000; snDirty = 3'b000;
        setSingle(2, 2'b00, 5'h04, 8'h00); issue(3'b100);
        // Invalidate from P2 with P1 and P3 sharing.
        snHit = 3'b101; setSingle(1, 2'b10, 5'h04, 8'h00); issue(3'b010);
        snHit = 3'b000;
        // All three ports requesting at once.
        for (int i = 0; i < 3; i++) setSingle(i, 2'b00, 5'(i + 16), 8'h00);
        issue(3'b111);
        // Two dirty owners: sticky protocol error, owner is the lower index.
        snHit = 3'b110; snDirty = 3'b110; snData[1] = 8'hA5; snData[2] = 8'h5A;
        setSingle(0, 2'b00, 5'h07, 8'h00); issue(3'b001);
        snHit = 3'b000; snDirty = 3'b000;
        setSingle(1, 2'b00, 5'h07, 8'h00); issue(3'b010);

        // Reset while the FSM sits in READ: aborted, outputs cleared, P1 gets next grant.
        setSingle(1, 2'b00, 5'h11, 8'h00);
        grantQ.push_back(3'b010);
        lastGrantM = 1;
        @(negedge clk);
        applySnoop();
        bus.req_cmd[1] = cmdA[1]; bus.req_tag[1] = tagA[1]; bus.req_data[1] = dataA[1];
        bus.req_valid = 3'b010;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (bus.req_ready[1] !== 1'b1 && budget < 20);
        if (budget >= 20) chk("abort_grant_timeout", 32'(budget), 32'd0);
        bus.req_valid = 3'b000;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs", allOutputs(), 32'd0);
        rst        = 1'b0;
        lastGrantM = 2;
        protoM     = 1'b0;
        grantQ.delete();
        setSingle(0, 2'b00, 5'h11, 8'h00);
        setSingle(2, 2'b11, 5'h12, 8'h9C);
        issue(3'b101);

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            pend = 3'($urandom_range(1, 7));
            for (int i = 0; i < 3; i++) begin
                setSingle(i, 2'($urandom_range(3)), 5'($urandom_range(31)), 8'($urandom_range(255)));
                snData[i] = 8'($urandom_range(255));
            end
            snHit   = 3'($urandom_range(7));
            snDirty = snHit & 3'($urandom_range(7));
            issue(pend);
        end

        repeat (3) @(negedge clk);
        if (respQ.size() != 0 || grantQ.size() != 0) begin
            chk("leftover_expectations", 32'(respQ.size() + grantQ.size()), 32'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "global timeout");
    end
endmodule
